// File: rtl/xtal_osc_ctrl_pkg.sv
// Shared state codes, default tuning values and a range helper for the
// 16 MHz crystal oscillator startup sequencer and clock-good monitor.
package xtal_osc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STARTUP = 3'd1,
        ST_CHECK   = 3'd2,
        ST_RUN     = 3'd3,
        ST_STBY    = 3'd4,
        ST_FAULT   = 3'd5
    } osc_state_t;

    localparam int DEF_WINDOW            = 256;
    localparam int DEF_MIN_EDGES         = 96;
    localparam int DEF_MAX_EDGES         = 109;
    localparam int DEF_STARTUP_CYCLES    = 65536;
    localparam int DEF_GOOD_WINDOWS      = 4;
    localparam int DEF_MAX_CHECK_WINDOWS = 32;

    function automatic logic in_range(input int unsigned count,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (count >= lo) && (count <= hi);
    endfunction

endpackage

// File: rtl/xtal_osc_freq_meter.sv
// Synchronises the crystal output, counts its rising edges over fixed
// system-clock windows and flags whether each completed window is in range.
module xtal_osc_freq_meter
    import xtal_osc_ctrl_pkg::*;
#(
    parameter int WINDOW    = DEF_WINDOW,
    parameter int MIN_EDGES = DEF_MIN_EDGES,
    parameter int MAX_EDGES = DEF_MAX_EDGES,
    parameter int CNT_W     = $clog2(WINDOW) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             osc_dout,
    input  logic             meter_run,
    input  logic             meter_clr,
    output logic             win_done,
    output logic             win_good,
    output logic [CNT_W-1:0] last_count
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             edge_q;
    logic             edge_p;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_total;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync_q1 <= osc_dout;
            sync_q2 <= sync_q1;
            edge_q  <= sync_q2;
        end
    end

    assign edge_p = sync_q2 & ~edge_q;

    // Count including this cycle's edge, saturating so a runaway input cannot wrap back into range.
    assign edge_total = (edge_p && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign win_done   = meter_run && (win_cnt == WIN_LAST);
    assign win_good   = in_range(32'(edge_total), MIN_EDGES, MAX_EDGES);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_cnt    <= '0;
            edge_cnt   <= '0;
            last_count <= '0;
        end else if (meter_clr) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else if (meter_run) begin
            if (win_done) begin
                win_cnt    <= '0;
                edge_cnt   <= '0;
                last_count <= edge_total;
            end else begin
                win_cnt  <= win_cnt + WIN_W'(1);
                edge_cnt <= edge_total;
            end
        end
    end

endmodule

// File: rtl/xtal_osc_ctrl.sv
// Crystal oscillator startup sequencer: drives ena/stdby, waits the settle
// time, then qualifies the clock over consecutive measurement windows.
module xtal_osc_ctrl
    import xtal_osc_ctrl_pkg::*;
#(
    parameter int WINDOW            = DEF_WINDOW,
    parameter int MIN_EDGES         = DEF_MIN_EDGES,
    parameter int MAX_EDGES         = DEF_MAX_EDGES,
    parameter int STARTUP_CYCLES    = DEF_STARTUP_CYCLES,
    parameter int GOOD_WINDOWS      = DEF_GOOD_WINDOWS,
    parameter int MAX_CHECK_WINDOWS = DEF_MAX_CHECK_WINDOWS,
    parameter int CNT_W             = $clog2(WINDOW) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             stdby_req,
    input  logic             osc_dout,
    output logic             osc_ena,
    output logic             osc_stdby,
    output logic             osc_good,
    output logic             osc_fault,
    output logic [CNT_W-1:0] last_count,
    output logic [2:0]       state
);

    localparam int TMR_W  = $clog2(STARTUP_CYCLES + 1);
    localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
    localparam int TOT_W  = $clog2(MAX_CHECK_WINDOWS + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(STARTUP_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_WINDOWS - 1);
    localparam logic [TOT_W-1:0]  TOT_LAST  = TOT_W'(MAX_CHECK_WINDOWS - 1);

    osc_state_t        state_q;
    logic [TMR_W-1:0]  settle_tmr;
    logic [GOOD_W-1:0] good_cnt;
    logic [TOT_W-1:0]  total_cnt;
    logic              win_done;
    logic              win_good;
    logic              meter_run;
    logic              meter_clr;

    // Every entry into CHECK starts the measurement from a fresh window boundary.
    assign meter_clr = en && (((state_q == ST_STARTUP) && (settle_tmr == TMR_LAST)) ||
                              ((state_q == ST_STBY) && !stdby_req));
    assign meter_run = (state_q == ST_CHECK) || (state_q == ST_RUN);

    xtal_osc_freq_meter #(
        .WINDOW    (WINDOW),
        .MIN_EDGES (MIN_EDGES),
        .MAX_EDGES (MAX_EDGES),
        .CNT_W     (CNT_W)
    ) u_meter (
        .clk        (clk),
        .resetn     (resetn),
        .osc_dout   (osc_dout),
        .meter_run  (meter_run),
        .meter_clr  (meter_clr),
        .win_done   (win_done),
        .win_good   (win_good),
        .last_count (last_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            settle_tmr <= '0;
            good_cnt   <= '0;
            total_cnt  <= '0;
        end else if (!en) begin
            state_q    <= ST_IDLE;
            settle_tmr <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    settle_tmr <= '0;
                    state_q    <= ST_STARTUP;
                end
                ST_STARTUP: begin
                    if (settle_tmr == TMR_LAST) begin
                        state_q   <= ST_CHECK;
                        good_cnt  <= '0;
                        total_cnt <= '0;
                    end else begin
                        settle_tmr <= settle_tmr + TMR_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (win_done) begin
                        total_cnt <= total_cnt + TOT_W'(1);
                        if (win_good) begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                            if (good_cnt == GOOD_LAST) begin
                                state_q <= ST_RUN;
                            end else if (total_cnt == TOT_LAST) begin
                                state_q <= ST_FAULT;
                            end
                        end else begin
                            good_cnt <= '0;
                            if (total_cnt == TOT_LAST) begin
                                state_q <= ST_FAULT;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (win_done && !win_good) begin
                        state_q <= ST_FAULT;
                    end else if (stdby_req) begin
                        state_q <= ST_STBY;
                    end
                end
                ST_STBY: begin
                    if (!stdby_req) begin
                        state_q   <= ST_CHECK;
                        good_cnt  <= '0;
                        total_cnt <= '0;
                    end
                end
                ST_FAULT: begin
                    state_q <= ST_FAULT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state     = state_q;
    assign osc_ena   = state_q inside {ST_STARTUP, ST_CHECK, ST_RUN, ST_STBY};
    assign osc_stdby = (state_q == ST_STBY);
    assign osc_good  = (state_q == ST_RUN);
    assign osc_fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_xtal_osc_ctrl.sv
// Directed bench for xtal_osc_ctrl: 40 MHz system clock, 16/8 MHz crystal model,
// short settle time; a second instance uses MAX_EDGES=102 for marginal counts.
`timescale 1ns/1ps
module tb_xtal_osc_ctrl;

    localparam int STARTUP = 100;
    localparam int WIN     = 256;
    localparam int T_GOOD  = 1 + STARTUP + 4 * WIN;
    localparam int T_FAULT = 1 + STARTUP + 32 * WIN;

    logic       clk       = 1'b0;
    logic       resetn    = 1'b0;
    logic       en        = 1'b0;
    logic       stdby_req = 1'b0;
    logic       en_m      = 1'b0;
    logic       stdby_m   = 1'b0;
    logic       osc_dout  = 1'b0;
    logic       osc_ena, osc_stdby, osc_good, osc_fault;
    logic [8:0] last_count;
    logic [2:0] state;
    logic       osc_ena_m, osc_stdby_m, osc_good_m, osc_fault_m;
    logic [8:0] last_count_m;
    logic [2:0] state_m;

    int  n_checks = 0;
    int  n_pass   = 0;
    real osc_half = 31.25;
    bit  osc_on   = 1'b0;

    xtal_osc_ctrl #(.STARTUP_CYCLES(STARTUP)) dut (
        .clk(clk), .resetn(resetn), .en(en), .stdby_req(stdby_req), .osc_dout(osc_dout),
        .osc_ena(osc_ena), .osc_stdby(osc_stdby), .osc_good(osc_good), .osc_fault(osc_fault),
        .last_count(last_count), .state(state)
    );

    xtal_osc_ctrl #(.STARTUP_CYCLES(STARTUP), .MAX_EDGES(102)) dut_m (
        .clk(clk), .resetn(resetn), .en(en_m), .stdby_req(stdby_m), .osc_dout(osc_dout),
        .osc_ena(osc_ena_m), .osc_stdby(osc_stdby_m), .osc_good(osc_good_m), .osc_fault(osc_fault_m),
        .last_count(last_count_m), .state(state_m)
    );

    always #12.5 clk = ~clk;

    always begin
        if (osc_on) begin
            #(osc_half);
            osc_dout = ~osc_dout;
        end else begin
            osc_dout = 1'b0;
            #1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        n_checks++; if (state !== 3'd0) $display("[TB] FAIL reset_state: got %0d expected 0", state); else n_pass++;
        n_checks++; if (osc_ena !== 1'b0) $display("[TB] FAIL reset_ena: got %b expected 0", osc_ena); else n_pass++;
        n_checks++; if (osc_stdby !== 1'b0) $display("[TB] FAIL reset_stdby: got %b expected 0", osc_stdby); else n_pass++;
        n_checks++; if (osc_good !== 1'b0) $display("[TB] FAIL reset_good: got %b expected 0", osc_good); else n_pass++;
        n_checks++; if (osc_fault !== 1'b0) $display("[TB] FAIL reset_fault: got %b expected 0", osc_fault); else n_pass++;
        n_checks++; if (last_count !== 9'd0) $display("[TB] FAIL reset_count: got %0d expected 0", last_count); else n_pass++;
        resetn = 1'b1;
        repeat (2) tick();
        n_checks++; if (state !== 3'd0) $display("[TB] FAIL idle_hold: got %0d expected 0", state); else n_pass++;
    endtask

    task automatic test_nominal_start();
        int cyc;
        osc_half = 31.25;
        osc_on   = 1'b1;
        repeat (20) tick();
        en = 1'b1;
        n_checks++; if (osc_ena !== 1'b0) $display("[TB] FAIL nom_ena_early: got %b expected 0", osc_ena); else n_pass++;
        tick();
        n_checks++; if (osc_ena !== 1'b1) $display("[TB] FAIL nom_ena: got %b expected 1", osc_ena); else n_pass++;
        n_checks++; if (state !== 3'd1) $display("[TB] FAIL nom_startup: got %0d expected 1", state); else n_pass++;
        cyc = 1;
        while (osc_good !== 1'b1 && cyc < T_GOOD + 50) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (osc_good !== 1'b1 || cyc < T_GOOD - 2 || cyc > T_GOOD + 2)
            $display("[TB] FAIL nom_good_time: got good=%b at cycle %0d expected 1 at %0d", osc_good, cyc, T_GOOD);
        else n_pass++;
        n_checks++;
        if (last_count != 102 && last_count != 103)
            $display("[TB] FAIL nom_count: got %0d expected 102 or 103", last_count);
        else n_pass++;
        n_checks++; if (state !== 3'd3) $display("[TB] FAIL nom_run: got %0d expected 3", state); else n_pass++;
    endtask

    task automatic test_standby();
        int cyc;
        stdby_req = 1'b1;
        tick();
        n_checks++; if (state !== 3'd4) $display("[TB] FAIL stby_state: got %0d expected 4", state); else n_pass++;
        n_checks++; if (osc_stdby !== 1'b1) $display("[TB] FAIL stby_pin: got %b expected 1", osc_stdby); else n_pass++;
        n_checks++; if (osc_good !== 1'b0) $display("[TB] FAIL stby_good: got %b expected 0", osc_good); else n_pass++;
        n_checks++; if (osc_ena !== 1'b1) $display("[TB] FAIL stby_ena: got %b expected 1", osc_ena); else n_pass++;
        repeat (600) tick();
        n_checks++; if (state !== 3'd4) $display("[TB] FAIL stby_hold: got %0d expected 4", state); else n_pass++;
        stdby_req = 1'b0;
        tick();
        n_checks++; if (state !== 3'd2) $display("[TB] FAIL stby_exit: got %0d expected 2", state); else n_pass++;
        n_checks++; if (osc_stdby !== 1'b0) $display("[TB] FAIL stby_release: got %b expected 0", osc_stdby); else n_pass++;
        cyc = 1;
        while (osc_good !== 1'b1 && cyc < 4 * WIN + 50) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (osc_good !== 1'b1 || cyc < 4 * WIN - 1 || cyc > 4 * WIN + 3)
            $display("[TB] FAIL stby_regood: got good=%b at cycle %0d expected 1 at %0d", osc_good, cyc, 4 * WIN + 1);
        else n_pass++;
    endtask

    // Entered right on a window boundary, so the next window is measured entirely at 8 MHz.
    task automatic test_freq_loss();
        int cyc;
        osc_half = 62.5;
        cyc = 0;
        while (state !== 3'd5 && cyc < 2 * WIN + 10) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (state !== 3'd5 || cyc > 2 * WIN + 2)
            $display("[TB] FAIL loss_fault: got state %0d after %0d cycles expected 5 within %0d", state, cyc, 2 * WIN + 2);
        else n_pass++;
        n_checks++;
        if (last_count < 49 || last_count > 54)
            $display("[TB] FAIL loss_count: got %0d expected about 51", last_count);
        else n_pass++;
        n_checks++; if (osc_good !== 1'b0) $display("[TB] FAIL loss_good: got %b expected 0", osc_good); else n_pass++;
        n_checks++; if (osc_fault !== 1'b1) $display("[TB] FAIL loss_fault_pin: got %b expected 1", osc_fault); else n_pass++;
        n_checks++; if (osc_ena !== 1'b0) $display("[TB] FAIL loss_ena: got %b expected 0", osc_ena); else n_pass++;
        en = 1'b0;
        tick();
        n_checks++; if (state !== 3'd0) $display("[TB] FAIL loss_idle: got %0d expected 0", state); else n_pass++;
        n_checks++; if (osc_fault !== 1'b0) $display("[TB] FAIL loss_clear: got %b expected 0", osc_fault); else n_pass++;
        osc_half = 31.25;
    endtask

    task automatic test_dead_osc();
        int cyc;
        bit saw_count;
        osc_on = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        cyc = 0;
        saw_count = 1'b0;
        while (state !== 3'd5 && cyc < T_FAULT + 20) begin
            tick();
            cyc++;
            if (cyc > 1 + STARTUP + WIN + 2 && last_count != 0) saw_count = 1'b1;
        end
        n_checks++;
        if (state !== 3'd5 || cyc < T_FAULT - 2 || cyc > T_FAULT + 2)
            $display("[TB] FAIL dead_fault_time: got state %0d at cycle %0d expected 5 at %0d", state, cyc, T_FAULT);
        else n_pass++;
        n_checks++; if (saw_count !== 1'b0) $display("[TB] FAIL dead_counts: got nonzero window count expected 0"); else n_pass++;
        n_checks++; if (last_count !== 9'd0) $display("[TB] FAIL dead_last: got %0d expected 0", last_count); else n_pass++;
        n_checks++; if (osc_fault !== 1'b1) $display("[TB] FAIL dead_fault_pin: got %b expected 1", osc_fault); else n_pass++;
        n_checks++; if (osc_ena !== 1'b0) $display("[TB] FAIL dead_ena: got %b expected 0", osc_ena); else n_pass++;
        repeat (10) tick();
        n_checks++; if (state !== 3'd5) $display("[TB] FAIL dead_hold: got %0d expected 5", state); else n_pass++;
        en = 1'b0;
        tick();
        n_checks++; if (state !== 3'd0) $display("[TB] FAIL dead_idle: got %0d expected 0", state); else n_pass++;
        n_checks++; if (osc_fault !== 1'b0) $display("[TB] FAIL dead_clear: got %b expected 0", osc_fault); else n_pass++;
    endtask

    task automatic test_marginal();
        int cyc;
        bit saw_run, saw102, saw103;
        osc_half = 31.25;
        osc_on   = 1'b1;
        repeat (10) tick();
        en_m = 1'b1;
        cyc = 0;
        saw_run = 1'b0;
        saw102 = 1'b0;
        saw103 = 1'b0;
        while (state_m !== 3'd5 && cyc < T_FAULT + 20) begin
            tick();
            cyc++;
            if (state_m === 3'd3) saw_run = 1'b1;
            if (cyc > 1 + STARTUP + WIN + 2 && last_count_m == 102) saw102 = 1'b1;
            if (cyc > 1 + STARTUP + WIN + 2 && last_count_m == 103) saw103 = 1'b1;
        end
        n_checks++; if (saw_run !== 1'b0) $display("[TB] FAIL marg_no_run: got run=1 expected 0"); else n_pass++;
        n_checks++;
        if (state_m !== 3'd5 || cyc < T_FAULT - 2 || cyc > T_FAULT + 2)
            $display("[TB] FAIL marg_fault_time: got state %0d at cycle %0d expected 5 at %0d", state_m, cyc, T_FAULT);
        else n_pass++;
        n_checks++;
        if (saw102 !== 1'b1 || saw103 !== 1'b1)
            $display("[TB] FAIL marg_counts: got saw102=%b saw103=%b expected both 1", saw102, saw103);
        else n_pass++;
        n_checks++; if (osc_fault_m !== 1'b1) $display("[TB] FAIL marg_fault_pin: got %b expected 1", osc_fault_m); else n_pass++;
        en_m = 1'b0;
        tick();
        n_checks++; if (state_m !== 3'd0) $display("[TB] FAIL marg_idle: got %0d expected 0", state_m); else n_pass++;
    endtask

    task automatic test_en_drop_startup();
        en = 1'b1;
        repeat (50) tick();
        n_checks++; if (state !== 3'd1) $display("[TB] FAIL drop_startup: got %0d expected 1", state); else n_pass++;
        en = 1'b0;
        tick();
        n_checks++; if (state !== 3'd0) $display("[TB] FAIL drop_idle: got %0d expected 0", state); else n_pass++;
        n_checks++; if (osc_ena !== 1'b0) $display("[TB] FAIL drop_ena: got %b expected 0", osc_ena); else n_pass++;
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        repeat (1 + STARTUP + WIN + 50) tick();
        n_checks++; if (state !== 3'd2) $display("[TB] FAIL areset_pre: got %0d expected 2", state); else n_pass++;
        n_checks++;
        if (last_count != 102 && last_count != 103)
            $display("[TB] FAIL areset_pre_count: got %0d expected 102 or 103", last_count);
        else n_pass++;
        @(posedge clk);
        #5;
        resetn = 1'b0;
        #1;
        n_checks++; if (state !== 3'd0) $display("[TB] FAIL areset_state: got %0d expected 0", state); else n_pass++;
        n_checks++; if (osc_ena !== 1'b0) $display("[TB] FAIL areset_ena: got %b expected 0", osc_ena); else n_pass++;
        n_checks++; if (last_count !== 9'd0) $display("[TB] FAIL areset_count: got %0d expected 0", last_count); else n_pass++;
        n_checks++; if (osc_good !== 1'b0 || osc_fault !== 1'b0 || osc_stdby !== 1'b0)
            $display("[TB] FAIL areset_flags: got good=%b fault=%b stdby=%b expected 0", osc_good, osc_fault, osc_stdby);
        else n_pass++;
        #3;
        en = 1'b0;
        resetn = 1'b1;
        tick();
        n_checks++; if (state !== 3'd0) $display("[TB] FAIL areset_after: got %0d expected 0", state); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal_start();
        test_standby();
        test_freq_loss();
        test_dead_osc();
        test_marginal();
        test_en_drop_startup();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
